// File: rtl/hex_disp_pkg.sv
// ============================================================================
// Module   : hex_disp_pkg
// Brief    : Shared constants and types for the multiplexed hex display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hex_disp_pkg;

    localparam int NIBBLE_W = 4;

    // Common-anode digit enables are active-low.
    localparam logic DIGIT_ON  = 1'b0;
    localparam logic DIGIT_OFF = 1'b1;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/scan_slot_timer.sv
// ============================================================================
// Module   : scan_slot_timer
// Brief    : Slot counter and BLANK/ON phase FSM; pulses slot_end on the last
//            ON cycle so the parent can advance to the next digit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_slot_timer
    import hex_disp_pkg::*;
#(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    output scan_state_t phase,
    output logic        slot_end
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_slot_last  = CNT_W'(SLOT_CYCLES - 1);

    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_slot_cnt;
    logic             w_slot_end;

    // The counter spans the whole slot, so it never exceeds SLOT_CYCLES-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= BLANK;
            r_slot_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_slot_cnt <= w_slot_end ? '0 : r_slot_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BLANK:   if (r_slot_cnt == c_blank_last) w_state_nxt = ON;
            ON:      if (r_slot_cnt == c_slot_last)  w_state_nxt = BLANK;
            default: w_state_nxt = BLANK;
        endcase
    end

    always_comb begin
        phase      = r_state;
        w_slot_end = (r_state == ON) && (r_slot_cnt == c_slot_last);
    end

    assign slot_end = w_slot_end;

endmodule

`default_nettype wire

// File: rtl/hex_digit_scanner.sv
// ============================================================================
// Module   : hex_digit_scanner
// Brief    : Scans a NUM_DIGITS hex value onto a shared 7-segment bus with a
//            tear-free valid/ready load path committed at frame boundaries.
//            Option HEX_SCAN_LEADING_ZERO_BLANK_EN blanks leading-zero digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_digit_scanner
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_valid,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] load_value,
    output logic                           load_ready,
    output logic [NIBBLE_W-1:0]            bin_num,
    output logic [NUM_DIGITS-1:0]          digit_sel,
    output logic [IDX_W-1:0]               digit_idx,
    output logic                           frame_tick
);

    localparam int VAL_W = NIBBLE_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_DIGITS - 1);

    logic [VAL_W-1:0]      r_display;
    logic [VAL_W-1:0]      r_pending;
    logic                  r_pending_full;
    logic [IDX_W-1:0]      r_digit_idx;
    logic [NIBBLE_W-1:0]   r_bin_num;

    scan_state_t           w_phase;
    logic                  w_slot_end;
    logic                  w_frame_end;
    logic                  w_load;
    logic                  w_commit;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [VAL_W-1:0]      w_display_nxt;
    logic [NIBBLE_W-1:0]   w_bin_nxt;
    logic [NUM_DIGITS-1:0] w_visible;

    scan_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .phase    (w_phase),
        .slot_end (w_slot_end)
    );

    assign w_frame_end   = w_slot_end && (r_digit_idx == c_last_idx);
    assign w_load        = load_valid && !r_pending_full;
    assign w_commit      = w_frame_end && r_pending_full;
    assign w_idx_nxt     = (r_digit_idx == c_last_idx) ? '0 : r_digit_idx + 1'b1;
    // Digit 0 of a new frame must already see the value committed on this edge.
    assign w_display_nxt = w_commit ? r_pending : r_display;

    always_comb begin
        w_bin_nxt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == IDX_W'(i)) w_bin_nxt = w_display_nxt[i*NIBBLE_W +: NIBBLE_W];
        end
    end

    // Commit and load are exclusive: commit needs a full pending, load an empty one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_display      <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_digit_idx    <= '0;
            r_bin_num      <= '0;
        end else begin
            if (w_commit) begin
                r_display      <= r_pending;
                r_pending_full <= 1'b0;
            end
            if (w_load) begin
                r_pending      <= load_value;
                r_pending_full <= 1'b1;
            end
            if (w_slot_end) begin
                r_digit_idx <= w_idx_nxt;
                r_bin_num   <= w_bin_nxt;
            end
        end
    end

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    always_comb begin : p_visible
        logic v_nonzero_above;
        v_nonzero_above = 1'b0;
        w_visible       = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_nonzero_above = v_nonzero_above | (|r_display[i*NIBBLE_W +: NIBBLE_W]);
            w_visible[i]    = (i == 0) || v_nonzero_above;
        end
    end
`else
    assign w_visible = '1;
`endif

    always_comb begin
        digit_sel = {NUM_DIGITS{DIGIT_OFF}};
        if ((w_phase == ON) && w_visible[r_digit_idx]) digit_sel[r_digit_idx] = DIGIT_ON;
    end

    assign load_ready = !r_pending_full;
    assign bin_num    = r_bin_num;
    assign digit_idx  = r_digit_idx;
    assign frame_tick = w_frame_end;

endmodule

`default_nettype wire

// File: tb/tb_hex_digit_scanner.sv
// ============================================================================
// Module   : tb_hex_digit_scanner
// Brief    : Scoreboard bench for hex_digit_scanner (4 digits, 8-cycle slots,
//            2 blank cycles); optional HEX_SCAN_LEADING_ZERO_BLANK_EN aware.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_digit_scanner;

    localparam int ND = 4;
    localparam int SC = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * SC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_value = 16'h0;
    logic        load_ready;
    logic [3:0]  bin_num;
    logic [3:0]  digit_sel;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] sb[$];
    logic        rst_q = 1'b0;

    hex_digit_scanner #(
        .NUM_DIGITS   (ND),
        .SLOT_CYCLES  (SC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
        .bin_num    (bin_num),
        .digit_sel  (digit_sel),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rst;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit visible(input logic [15:0] v, input int s);
`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
        return (s == 0) || ((v >> (4 * s)) != 16'h0);
`else
        return 1'b1;
`endif
    endfunction

    // Monitor: cycle-position model for select/index/tick, per-frame value pop.
    initial begin : monitor
        int          cyc;
        bit          started;
        logic [15:0] obs;
        logic [15:0] cur;
        cyc = 0;
        started = 1'b0;
        obs = 16'h0;
        forever begin
            @(negedge clk);
            if (rst_q) begin
                started = 1'b1;
                cyc = 0;
                obs = 16'h0;
            end else if (started) begin
                cyc++;
            end
            if (started) begin
                int         pos;
                int         slot;
                logic [3:0] sel_exp;
                pos  = cyc % SC;
                slot = (cyc / SC) % ND;
                cur  = (sb.size() > 0) ? sb[0] : 16'h0;
                sel_exp = 4'hF;
                if (pos >= BC && visible(cur, slot)) sel_exp[slot] = 1'b0;
                chk("digit_sel", digit_sel, sel_exp);
                chk("digit_idx", digit_idx, slot);
                chk("frame_tick", frame_tick, (cyc % FRAME) == FRAME - 1);
                if (pos == 0) obs[slot*4 +: 4] = bin_num;
                else chk("bin_stable", bin_num, obs[slot*4 +: 4]);
                if ((cyc % FRAME) == FRAME - 1) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_underflow: frame ended with %0h, no expected value queued", obs);
                    end else begin
                        chk("frame_value", obs, sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 100);
        if (!frame_tick) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_tick: frame_tick not seen within 100 cycles at %0t", $time);
        end
    endtask

    // Leaves load_valid asserted so consecutive offers form a held stream.
    task automatic offer(input logic [15:0] v);
        int n = 0;
        load_valid = 1'b1;
        load_value = v;
        while (!load_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!load_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL offer: load_ready stuck low for value %0h", v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        int n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", load_ready, 1);
        chk("rst_bin", bin_num, 0);
        chk("rst_sel", digit_sel, 4'hF);
        chk("rst_idx", digit_idx, 0);
        chk("rst_tick", frame_tick, 0);
        rst = 1'b0;
        sb.push_back(16'h0000);
        sb.push_back(16'h0000);

        wait_tick();
        repeat (10) @(posedge clk);
        #1;
        sb.push_back(16'hA3F0);
        chk("ready_idle", load_ready, 1);
        offer(16'hA3F0);
        load_valid = 1'b0;
        chk("ready_after_load", load_ready, 0);
        wait_tick();
        chk("ready_at_commit", load_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_commit", load_ready, 1);

        repeat (4) @(posedge clk);
        #1;
        sb.push_back(16'h1111);
        sb.push_back(16'h2222);
        offer(16'h1111);
        chk("ready_first_held", load_ready, 0);
        offer(16'h2222);
        load_valid = 1'b0;
        chk("ready_second_held", load_ready, 0);
        sb.push_back(16'h2222);
        sb.push_back(16'h5A5A);

        wait_tick();
        wait_tick();
        load_valid = 1'b1;
        load_value = 16'h5A5A;
        chk("ready_on_tick", load_ready, 1);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        chk("ready_after_tick_load", load_ready, 0);
        wait_tick();
        chk("ready_full_at_tick", load_ready, 0);

        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        offer(16'h0F0F);
        load_valid = 1'b0;
        chk("ready_pending_full", load_ready, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(digit_idx == 2'd2 && digit_sel != 4'hF) && n < 100);
        if (!(digit_idx == 2'd2 && digit_sel != 4'hF)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_digit2: digit 2 ON phase not seen, idx %0d sel %0h", digit_idx, digit_sel);
        end
        #1;
        sb.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_sel", digit_sel, 4'hF);
        chk("midrst_idx", digit_idx, 0);
        chk("midrst_bin", bin_num, 0);
        chk("midrst_tick", frame_tick, 0);
        chk("midrst_ready", load_ready, 1);
        rst = 1'b0;
        sb.push_back(16'h0000);
        sb.push_back(16'h0050);
        sb.push_back(16'h0050);

        repeat (5) @(posedge clk);
        #1;
        offer(16'h0050);
        load_valid = 1'b0;
        wait_tick();
        wait_tick();
        wait_tick();
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
